ball_ctrl: RTL and testbench
============================

BALL_CTRL -- requirements
Module: ball_ctrl

Interface
REQ-001 Parameter SERVE_FRAMES, default 60: frames the ball is held at centre before each serve.
REQ-002 Parameter WIN_SCORE, default 9: score that ends the game.
REQ-003 The block SHALL use one clock and one reset: clk, a 1-bit input, the 31.5 MHz pixel clock; reset, a 1-bit input, synchronous, active-high.
REQ-004 The block SHALL have these data ports:
- frame_tick, in, 1: one-cycle pulse once per frame (vsync edge); all game updates occur only on it.
- l_up, l_down, r_up, r_down, in, 1 each: paddle buttons, already synchronised to clk.
- start, in, 1: restart request.
- ball_x, ball_y, out, 8 each: ball pixel position.
- lpaddle, rpaddle, out, 16 each: row masks; bit n lights rows 16n..16n+15; lpaddle is drawn in column x 240..255, rpaddle in x 0..15.
- score_l, score_r, out, 4 each: scores.
- switch_background, out, 1: toggles once per scoring event.
- game_over, out, 1: high in state OVER.

Function
REQ-005 Each paddle SHALL be a 4-bit top row pos 0..13; mask = 16'b111 << pos.
REQ-006 On frame_tick in any state, for each paddle: if only up is pressed and pos>0, then pos-1; if only down is pressed and pos<13, then pos+1; if both or neither are pressed, no move; pos saturates at 0 and 13.
REQ-007 The FSM SHALL have states SERVE, PLAY, SCORE, OVER.
REQ-008 SERVE: ball = (128,128); a frame counter counts frame_ticks; after SERVE_FRAMES ticks, go to PLAY with speed=1.
REQ-009 PLAY, on each frame_tick: x and y each move by speed in directions dx and dy; arithmetic is 9-bit and the result is clamped as below.
REQ-010 Y walls:
- If dy is up and ball_y <= speed: ball_y := 0 and dy flips.
- If dy is down and ball_y + speed >= 255: ball_y := 255 and dy flips.
REQ-011 Left edge (dx left): if ball_x <= 16+speed, then ball_x := 16 and rpaddle[ball_y[7:4]] is tested in the same update. Hit: dx := right. Miss: go to SCORE, credit player L.
REQ-012 Right edge (dx right): if ball_x + speed >= 239, then ball_x := 239 and lpaddle[ball_y[7:4]] is tested. Hit: dx := left. Miss: go to SCORE, credit player R.
REQ-013 The paddle test SHALL use paddle masks from before this frame's paddle move.
REQ-014 A wall bounce and a paddle event in the same frame SHALL both apply.
REQ-015 SCORE, exactly one clk cycle:
- Increment the credited score.
- Toggle switch_background.
- The next serve dx points toward the player who missed.
- Ball holds its position.
- If the new score == WIN_SCORE, go to OVER; otherwise go to SERVE with the frame counter cleared.
REQ-016 OVER: ball held at (128,128); game_over=1; scores frozen. start=1 clears both scores and goes to SERVE in the next cycle. start is ignored in other states.
REQ-017 A frame_tick arriving in the SCORE cycle SHALL be ignored for ball motion, but it still moves the paddles.
REQ-018 Outputs SHALL be registered; a frame_tick at cycle t updates the outputs at t+1.

Reset
REQ-019 When reset=1 at a clk edge, the block SHALL set: state SERVE; frame counter 0; ball (128,128); dx right, dy down; speed 1; both pos = 6 (mask 16'h01C0); scores 0; switch_background 0; game_over 0.
REQ-020 Reset SHALL take priority over all inputs in every state, including mid-PLAY and OVER.

Configuration
REQ-021 With macro BALL_SPEEDUP_EN defined, each paddle hit SHALL increment speed, saturating at 4, and speed SHALL return to 1 at each serve.
REQ-022 Without BALL_SPEEDUP_EN, speed SHALL be constant 1 and no speed register is built.

Verification
REQ-023 Reset, then 60 frame_ticks -> the state enters PLAY; the tick after that gives ball (129,129).
REQ-024 Ball moving up at y=1, speed 1, then a tick -> ball_y=0 and dy=down; the next tick gives ball_y=1.
REQ-025 rpaddle pos=6, ball moving left at (17,100), then a tick -> ball_x=16 and dx=right (row 6 lit); repeat with pos=0 -> SCORE, score_l=1, switch_background toggles, next state SERVE.
REQ-026 l_up held for 20 ticks from pos 6 -> pos stops at 0 and lpaddle=16'h0007; l_up and l_down together -> no change.
REQ-027 score_r=8 and a right-edge miss -> score_r=9, game_over=1, ball (128,128); start -> scores 0, state SERVE; reset asserted mid-PLAY -> all REQ-019 values on the next cycle.
REQ-028 With BALL_SPEEDUP_EN, 5 consecutive hits -> speed=4 (saturated); after a miss and serve, speed=1.

Source files
------------

// File: rtl/ball_ctrl.sv
// ball_ctrl: Pong-style ball/paddle/score controller, updated once per frame_tick.
// Optional feature: define BALL_SPEEDUP_EN to make each paddle hit raise the
// ball speed (1..4). The speed returns to 1 on every serve. Without the macro,
// the speed is fixed at 1 and no speed register exists.
module ball_ctrl #(
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        l_up,
    input  logic        l_down,
    input  logic        r_up,
    input  logic        r_down,
    input  logic        start,
    output logic [7:0]  ball_x,
    output logic [7:0]  ball_y,
    output logic [15:0] lpaddle,
    output logic [15:0] rpaddle,
    output logic [3:0]  score_l,
    output logic [3:0]  score_r,
    output logic        switch_background,
    output logic        game_over
);

    localparam int CW = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

    typedef enum logic [1:0] {S_SERVE, S_PLAY, S_SCORE, S_OVER} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] frame_cnt_q, frame_cnt_d;
    logic [7:0]    ball_x_q, ball_x_d, ball_y_q, ball_y_d;
    logic          dx_q, dx_d;   // 1 = moving right (toward the lpaddle column)
    logic          dy_q, dy_d;   // 1 = moving down
    logic [3:0]    lpos_q, lpos_d, rpos_q, rpos_d;
    logic [3:0]    score_l_q, score_l_d, score_r_q, score_r_d;
    logic          bg_q, bg_d;
    logic [2:0]    speed;

    logic [8:0]    spd9, x_inc, x_dec, y_inc, y_dec;
    logic [3:0]    score_l_inc, score_r_inc;

    // One paddle step: a single pressed button moves one row, saturating at 0/13
    function automatic logic [3:0] paddle_step(input logic [3:0] pos,
                                               input logic up, input logic dn);
        logic [3:0] r;
        r = pos;
        if (up && !dn && pos != 4'd0)
            r = pos - 4'd1;
        else if (dn && !up && pos < 4'd13)
            r = pos + 4'd1;
        return r;
    endfunction

`ifdef BALL_SPEEDUP_EN
    logic [2:0] speed_q, speed_d;
    assign speed = speed_q;

    // Speed: back to 1 while serving, +1 per paddle hit (a dx flip in PLAY), max 4
    always_comb begin
        speed_d = speed_q;
        if (state_q == S_SERVE)
            speed_d = 3'd1;
        else if (state_q == S_PLAY && dx_d != dx_q && speed_q < 3'd4)
            speed_d = speed_q + 3'd1;
    end

    // Speed register
    always_ff @(posedge clk) begin
        if (reset) speed_q <= 3'd1;
        else       speed_q <= speed_d;
    end
`else
    assign speed = 3'd1;
`endif

    assign spd9        = {6'd0, speed};
    assign x_inc       = {1'b0, ball_x_q} + spd9;
    assign x_dec       = {1'b0, ball_x_q} - spd9;
    assign y_inc       = {1'b0, ball_y_q} + spd9;
    assign y_dec       = {1'b0, ball_y_q} - spd9;
    assign score_l_inc = score_l_q + 4'd1;
    assign score_r_inc = score_r_q + 4'd1;

    assign lpaddle           = 16'h0007 << lpos_q;
    assign rpaddle           = 16'h0007 << rpos_q;
    assign ball_x            = ball_x_q;
    assign ball_y            = ball_y_q;
    assign score_l           = score_l_q;
    assign score_r           = score_r_q;
    assign switch_background = bg_q;
    assign game_over         = (state_q == S_OVER);

    // Next-state: paddles on every tick, ball/score per game state
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        ball_x_d    = ball_x_q;
        ball_y_d    = ball_y_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        lpos_d      = lpos_q;
        rpos_d      = rpos_q;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        bg_d        = bg_q;

        if (frame_tick) begin
            lpos_d = paddle_step(lpos_q, l_up, l_down);
            rpos_d = paddle_step(rpos_q, r_up, r_down);
        end

        unique case (state_q)
            S_SERVE: begin
                ball_x_d = 8'd128;
                ball_y_d = 8'd128;
                if (frame_tick) begin
                    if (frame_cnt_q == CW'(SERVE_FRAMES - 1)) begin
                        frame_cnt_d = '0;
                        state_d     = S_PLAY;
                    end else begin
                        frame_cnt_d = frame_cnt_q + CW'(1);
                    end
                end
            end
            S_PLAY: begin
                if (frame_tick) begin
                    // Vertical walls clamp and reflect
                    if (!dy_q) begin
                        if ({1'b0, ball_y_q} <= spd9) begin
                            ball_y_d = 8'd0;
                            dy_d     = 1'b1;
                        end else begin
                            ball_y_d = y_dec[7:0];
                        end
                    end else if (y_inc >= 9'd255) begin
                        ball_y_d = 8'd255;
                        dy_d     = 1'b0;
                    end else begin
                        ball_y_d = y_inc[7:0];
                    end
                    // Paddle edges: test the row of the pre-move ball against pre-move masks
                    if (!dx_q) begin
                        if ({1'b0, ball_x_q} <= 9'd16 + spd9) begin
                            ball_x_d = 8'd16;
                            if (rpaddle[ball_y_q[7:4]]) dx_d    = 1'b1;
                            else                        state_d = S_SCORE;
                        end else begin
                            ball_x_d = x_dec[7:0];
                        end
                    end else if (x_inc >= 9'd239) begin
                        ball_x_d = 8'd239;
                        if (lpaddle[ball_y_q[7:4]]) dx_d    = 1'b0;
                        else                        state_d = S_SCORE;
                    end else begin
                        ball_x_d = x_inc[7:0];
                    end
                end
            end
            S_SCORE: begin
                // dx is left untouched by a miss, so it still points at the edge
                // that was missed: that names the scorer and is the next serve dx.
                bg_d        = ~bg_q;
                frame_cnt_d = '0;
                if (!dx_q) begin
                    score_l_d = score_l_inc;
                    state_d   = (score_l_inc == 4'(WIN_SCORE)) ? S_OVER : S_SERVE;
                end else begin
                    score_r_d = score_r_inc;
                    state_d   = (score_r_inc == 4'(WIN_SCORE)) ? S_OVER : S_SERVE;
                end
            end
            S_OVER: begin
                ball_x_d = 8'd128;
                ball_y_d = 8'd128;
                if (start) begin
                    score_l_d   = 4'd0;
                    score_r_d   = 4'd0;
                    frame_cnt_d = '0;
                    state_d     = S_SERVE;
                end
            end
            default: state_d = S_SERVE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_SERVE;
            frame_cnt_q <= '0;
            ball_x_q    <= 8'd128;
            ball_y_q    <= 8'd128;
            dx_q        <= 1'b1;
            dy_q        <= 1'b1;
            lpos_q      <= 4'd6;
            rpos_q      <= 4'd6;
            score_l_q   <= 4'd0;
            score_r_q   <= 4'd0;
            bg_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            ball_x_q    <= ball_x_d;
            ball_y_q    <= ball_y_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            lpos_q      <= lpos_d;
            rpos_q      <= rpos_d;
            score_l_q   <= score_l_d;
            score_r_q   <= score_r_d;
            bg_q        <= bg_d;
        end
    end

endmodule

// File: tb/tb_ball_ctrl.sv
// tb_ball_ctrl: directed checks of ball_ctrl with hand-computed trajectories.
module tb_ball_ctrl;

    logic        clk = 1'b0;
    logic        reset, frame_tick, l_up, l_down, r_up, r_down, start;
    logic [7:0]  ball_x, ball_y;
    logic [15:0] lpaddle, rpaddle;
    logic [3:0]  score_l, score_r;
    logic        switch_background, game_over;

    int checks = 0;
    int errors = 0;

    ball_ctrl dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .l_up(l_up), .l_down(l_down), .r_up(r_up), .r_down(r_down), .start(start),
        .ball_x(ball_x), .ball_y(ball_y), .lpaddle(lpaddle), .rpaddle(rpaddle),
        .score_l(score_l), .score_r(score_r),
        .switch_background(switch_background), .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        tk, lu, ld, ru, rd;
        logic [15:0] exp_l, exp_r;
    } pvec_t;

    pvec_t pv [0:7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic ball(input string nm, input logic [7:0] x, input logic [7:0] y);
        chk({nm, " ball_x"}, 32'(ball_x), 32'(x));
        chk({nm, " ball_y"}, 32'(ball_y), 32'(y));
    endtask

    task automatic pulse_reset();
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
    endtask

    task automatic check_reset_vals(input string nm);
        ball(nm, 8'd128, 8'd128);
        chk({nm, " lpaddle"}, 32'(lpaddle), 32'h01C0);
        chk({nm, " rpaddle"}, 32'(rpaddle), 32'h01C0);
        chk({nm, " score_l"}, 32'(score_l), 32'd0);
        chk({nm, " score_r"}, 32'(score_r), 32'd0);
        chk({nm, " bg"}, 32'(switch_background), 32'd0);
        chk({nm, " game_over"}, 32'(game_over), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; frame_tick = 1'b0; start = 1'b0;
        l_up = 1'b0; l_down = 1'b0; r_up = 1'b0; r_down = 1'b0;

        //            tk    lu    ld    ru    rd    lpaddle  rpaddle
        pv[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h00E0, 16'h01C0};
        pv[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h00E0, 16'h01C0};
        pv[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00E0, 16'h0380};
        pv[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h00E0, 16'h0380};
        pv[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h01C0, 16'h01C0};
        pv[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h01C0, 16'h01C0};
        pv[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0380, 16'h0380};
        pv[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0380, 16'h0380};

        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_reset_vals("reset");

        // Paddle movement table
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            frame_tick = pv[i].tk;
            l_up = pv[i].lu; l_down = pv[i].ld; r_up = pv[i].ru; r_down = pv[i].rd;
            @(negedge clk);
            frame_tick = 1'b0;
            l_up = 1'b0; l_down = 1'b0; r_up = 1'b0; r_down = 1'b0;
            chk($sformatf("paddle vec %0d lpaddle", i), 32'(lpaddle), 32'(pv[i].exp_l));
            chk($sformatf("paddle vec %0d rpaddle", i), 32'(rpaddle), 32'(pv[i].exp_r));
        end
        l_up = 1'b1; r_down = 1'b1;
        ticks(20);
        chk("l_up saturate lpaddle", 32'(lpaddle), 32'h0007);
        chk("r_down saturate rpaddle", 32'(rpaddle), 32'hE000);
        l_down = 1'b1;
        tick();
        l_up = 1'b0; l_down = 1'b0; r_down = 1'b0;
        chk("both pressed lpaddle", 32'(lpaddle), 32'h0007);
        chk("both pressed rpaddle", 32'(rpaddle), 32'hE000);

        // Serve after reset
        pulse_reset();
        check_reset_vals("reset2");
        ticks(59);
        ball("serve59", 8'd128, 8'd128);
        tick();
        ball("serve60", 8'd128, 8'd128);
        l_down = 1'b1; r_up = 1'b1;
        tick();
        ball("play k1", 8'd129, 8'd129);
        ticks(2);
        r_up = 1'b0;
        ticks(3);
        l_down = 1'b0;
        chk("k6 lpaddle", 32'(lpaddle), 32'h7000);
        chk("k6 rpaddle", 32'(rpaddle), 32'h0038);
        ticks(104);
        ball("k110", 8'd238, 8'd238);
        tick();
        ball("right hit k111", 8'd239, 8'd239);

`ifndef BALL_SPEEDUP_EN
        tick();
        ball("after right hit", 8'd238, 8'd240);
        ticks(14);
        tick();
        ball("bottom wall", 8'd223, 8'd255);
        tick();
        ball("after bottom wall", 8'd222, 8'd254);
        ticks(205);
        ball("k333", 8'd17, 8'd49);
        tick();
        ball("left hit", 8'd16, 8'd48);
        tick();
        ball("after left hit", 8'd17, 8'd47);
        ticks(45);
        tick();
        ball("y=1 up", 8'd63, 8'd1);
        tick();
        ball("top wall", 8'd64, 8'd0);
        tick();
        ball("after top wall", 8'd65, 8'd1);
        ticks(173);
        ball("k556", 8'd238, 8'd174);
        // Miss followed by a tick landing in the SCORE cycle
        @(negedge clk); frame_tick = 1'b1; l_up = 1'b1;
        @(negedge clk);
        @(negedge clk); frame_tick = 1'b0; l_up = 1'b0;
        ball("score hold", 8'd239, 8'd175);
        chk("score-cycle tick lpaddle", 32'(lpaddle), 32'h1C00);
        chk("right miss score_r", 32'(score_r), 32'd1);
        chk("right miss score_l", 32'(score_l), 32'd0);
        chk("right miss bg", 32'(switch_background), 32'd1);
        cyc();
        ball("serve recentre", 8'd128, 8'd128);
        // Round 2: hit on the right, miss on the left
        l_down = 1'b1; r_up = 1'b1;
        ticks(2);
        l_down = 1'b0;
        tick();
        r_up = 1'b0;
        ticks(57);
        chk("round2 lpaddle", 32'(lpaddle), 32'h7000);
        chk("round2 rpaddle", 32'(rpaddle), 32'h0007);
        ticks(111);
        ball("round2 right hit", 8'd239, 8'd239);
        ticks(223);
        ball("left miss", 8'd16, 8'd48);
        cyc();
        chk("left miss score_l", 32'(score_l), 32'd1);
        chk("left miss score_r", 32'(score_r), 32'd1);
        chk("left miss bg", 32'(switch_background), 32'd0);
`else
        r_up = 1'b1;
        tick();
        ball("speed2 after hit", 8'd237, 8'd241);
        ticks(2);
        r_up = 1'b0;
        ticks(109);
        ball("speed2 left miss", 8'd16, 8'd47);
        cyc();
        chk("speedup miss score_l", 32'(score_l), 32'd1);
        ticks(61);
        ball("speed back to 1", 8'd127, 8'd127);
`endif

        // Nine right-edge misses end the game; start is ignored outside OVER
        pulse_reset();
        check_reset_vals("reset3");
        start = 1'b1;
        for (int r = 1; r <= 9; r++) begin
            ticks(171);
            cyc();
            start = 1'b0;
            chk($sformatf("round %0d score_r", r), 32'(score_r), 32'(r));
            chk($sformatf("round %0d game_over", r), 32'(game_over), (r == 9) ? 32'd1 : 32'd0);
            if (r == 1) chk("round 1 bg", 32'(switch_background), 32'd1);
        end
        chk("over score_l", 32'(score_l), 32'd0);
        cyc();
        ball("over centre", 8'd128, 8'd128);
        l_up = 1'b1;
        ticks(3);
        l_up = 1'b0;
        ball("over frozen", 8'd128, 8'd128);
        chk("over frozen score_r", 32'(score_r), 32'd9);
        chk("over game_over", 32'(game_over), 32'd1);
        chk("over paddles move", 32'(lpaddle), 32'h0038);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("restart score_r", 32'(score_r), 32'd0);
        chk("restart game_over", 32'(game_over), 32'd0);
        ticks(60);
        ball("restart serve", 8'd128, 8'd128);
        tick();
        ball("restart play", 8'd129, 8'd129);
        ticks(4);
        ball("before reset", 8'd133, 8'd133);

        // Reset mid-PLAY beats every other input
        @(negedge clk);
        reset = 1'b1; frame_tick = 1'b1; start = 1'b1; l_down = 1'b1;
        @(negedge clk);
        reset = 1'b0; frame_tick = 1'b0; start = 1'b0; l_down = 1'b0;
        check_reset_vals("reset mid-play");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
